seven_seg_scan_ctrl: RTL
========================

Name: seven_seg_scan_ctrl

Overview:
Time-multiplexing scan controller for a common multi-digit 7-segment display. It owns one shared BCD-to-segment decoder and drives it with one digit's BCD code at a time, with the matching one-hot digit enable. Holds a double-buffered copy of all digits so host updates never tear a frame. Sits between the host/counter logic producing BCD digits and the decoder plus display pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8)
PRESCALE, 1000, clock cycles each digit is shown per SHOW slot (>=1)
BLANK_CYCLES, 2, all-off guard cycles before each digit to prevent ghosting (0 = no guard)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
enable  input  1  1 = scanning, 0 = display dark (IDLE)
load  input  1  single-cycle strobe; capture digits_in into shadow buffer
digits_in  input  4*NUM_DIGITS  BCD digits; digit i = digits_in[4*i+3:4*i], digit 0 = least significant
bcd_out  output  4  BCD code to the shared decoder; 4'hF = blank (decoder default, all segments off)
digit_en  output  NUM_DIGITS  one-hot active-high digit select
frame_done  output  1  one-cycle pulse at end of last digit's SHOW slot

Behaviour:
- One clock; reset is synchronous and active-low: clk rising edge, rst_n sampled low -> reset.
- Reset values: state=IDLE, digit_en=0, bcd_out=4'hF, frame_done=0, digit index=0, slot counter=0, shadow and active buffers=0.
- All outputs registered; they reflect the current state register (no combinational input-to-output path).
- Shadow buffer: load=1 -> shadow<=digits_in at that edge, in any state, including IDLE.
- Active buffer: copied from shadow only at frame boundaries (IDLE->scan entry and end of digit NUM_DIGITS-1). If load=1 on the copy cycle, active takes digits_in directly (bypass).
- States:
  IDLE: digit_en=0, bcd_out=F. enable=1 -> BLANK (or SHOW if BLANK_CYCLES=0), index=0, active copied.
  BLANK: digit_en=0, bcd_out=F for exactly BLANK_CYCLES cycles -> SHOW.
  SHOW: digit_en=1<<index, bcd_out=active[4*index+:4] for exactly PRESCALE cycles. At last cycle: if index=NUM_DIGITS-1 -> frame_done=1 on the next cycle (first cycle of the following slot), index=0, active copied; else index+1. Next state BLANK (or SHOW if BLANK_CYCLES=0).
- Frame period = NUM_DIGITS*(BLANK_CYCLES+PRESCALE) cycles; frame_done exactly once per period.
- enable=0 in any state: next edge -> IDLE, outputs dark, counters cleared, partial frame discarded, no frame_done. Re-enable always restarts at digit 0.
- Non-BCD digit values (A..F) are passed through unchanged; the decoder blanks them.
- rst_n low mid-operation overrides everything including load and enable.

Optional Feature:
LEADING_ZERO_BLANK_EN: when defined, during SHOW any digit that is 0 and has all higher-index active digits also 0 drives bcd_out=4'hF (digit_en still asserted). Digit 0 is never blanked (value 0 shows "0"). When undefined, every digit is shown as stored.

Test Plan:
Use NUM_DIGITS=4, PRESCALE=4, BLANK_CYCLES=1.
- rst_n low 3 cycles with enable=1, load=1 -> digit_en=0000, bcd_out=F, frame_done=0 throughout; after release, scanning starts with active=0000.
- load 16'h1234 then enable=1 -> 1 blank cycle, digit_en=0001/bcd=4 for 4 cycles, blank, 0010/3, blank, 0100/2, blank, 1000/1; frame_done pulse 20 cycles after scanning starts, then repeat.
- load 16'h5678 while digit 1 shows -> rest of frame shows 2,1; next frame shows 8,7,6,5.
- enable=0 during SHOW of digit 2 -> next cycle digit_en=0, bcd=F, no frame_done; enable=1 -> restart at digit 0 after 1 blank cycle.
- BLANK_CYCLES=0 build, load 16'h9876 -> digit_en changes directly 0001->0010 with no dark cycle; period 16 cycles.
- LEADING_ZERO_BLANK_EN defined: 16'h0040 -> bcd F,F,4,0 for digits 3..0; 16'h0000 -> F,F,F,0; undefined: 0,0,4,0.

Source files
------------

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit 7-segment display with a
// double-buffered digit store. Optional `LEADING_ZERO_BLANK_EN blanks leading zeros.
module seven_seg_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int PRESCALE     = 1000,
   parameter int BLANK_CYCLES = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   output logic [3:0]              bcd_out,
   output logic [NUM_DIGITS-1:0]   digit_en,
   output logic                    frame_done
);

   localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(PRESCALE - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

   localparam state_t SLOT_START = (BLANK_CYCLES == 0) ? SHOW : BLANK;

   state_t                  state, state_next;
   logic [CNT_W-1:0]        cnt, cnt_next;
   logic [IDX_W-1:0]        idx, idx_next;
   logic [4*NUM_DIGITS-1:0] shadow, shadow_next;
   logic [4*NUM_DIGITS-1:0] active, active_next;
   logic [4*NUM_DIGITS-1:0] copy_value;
   logic                    frame_done_next;
   logic [3:0]              cur_digit;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         idx        <= '0;
         shadow     <= '0;
         active     <= '0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_next;
         cnt        <= cnt_next;
         idx        <= idx_next;
         shadow     <= shadow_next;
         active     <= active_next;
         frame_done <= frame_done_next;
      end
   end

   // A load coinciding with a frame-boundary copy bypasses the shadow buffer.
   always_comb begin
      copy_value      = load ? digits_in : shadow;
      shadow_next     = copy_value;
      state_next      = state;
      cnt_next        = cnt;
      idx_next        = idx;
      active_next     = active;
      frame_done_next = 1'b0;

      if (!enable) begin
         state_next = IDLE;
         cnt_next   = '0;
         idx_next   = '0;
      end else begin
         case (state)
            IDLE: begin
               state_next  = SLOT_START;
               cnt_next    = '0;
               idx_next    = '0;
               active_next = copy_value;
            end
            BLANK: begin
               if (cnt == BLANK_LAST) begin
                  state_next = SHOW;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt + 1'b1;
               end
            end
            SHOW: begin
               if (cnt == SHOW_LAST) begin
                  state_next = SLOT_START;
                  cnt_next   = '0;
                  if (idx == IDX_LAST) begin
                     idx_next        = '0;
                     active_next     = copy_value;
                     frame_done_next = 1'b1;
                  end else begin
                     idx_next = idx + 1'b1;
                  end
               end else begin
                  cnt_next = cnt + 1'b1;
               end
            end
            default: begin
               state_next = IDLE;
               cnt_next   = '0;
               idx_next   = '0;
            end
         endcase
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic lead_zero;

   // The current digit is a leading zero when it and every higher digit are zero.
   always_comb begin
      lead_zero = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (i >= int'(idx) && active[4*i +: 4] != 4'h0) lead_zero = 1'b0;
      end
   end
`endif

   always_comb begin
      cur_digit = 4'hF;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (i == int'(idx)) cur_digit = active[4*i +: 4];
      end
      digit_en = '0;
      bcd_out  = 4'hF;
      if (state == SHOW) begin
         digit_en = NUM_DIGITS'(1) << idx;
`ifdef LEADING_ZERO_BLANK_EN
         bcd_out  = (lead_zero && idx != '0) ? 4'hF : cur_digit;
`else
         bcd_out  = cur_digit;
`endif
      end
   end

endmodule
